// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg
//   Shared types and constants for the shift sequencer slice.
//   - state_e     : sequencer FSM states (IDLE/LOAD/SHIFT/DONE)
//   - DIR_LEFT/RIGHT : direction encoding for the command port
//   - core_ctrl_t : per-cycle control bundle driven from the FSM into shift_core
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Control bundle for the datapath register; width-independent so it can
  // live in the package regardless of NOBIT.
  typedef struct packed {
    logic load;       // load i_load_data this edge
    logic shift_en;   // shift this edge
    logic shift_two;  // 1: shift 2 positions, 0: shift 1 position
    logic dir;        // DIR_LEFT / DIR_RIGHT
    logic fill;       // bit inserted into vacated positions
  } core_ctrl_t;

endpackage

// File: rtl/shift_core.sv
// shift_core
//   NOBIT-bit shift register with synchronous load, 1- or 2-position shift,
//   direction and fill select, and synchronous active-low clear.
//   Ports:
//     i_clk       clock, rising edge
//     i_clr_      synchronous active-low clear (register -> 0)
//     i_ctrl      load / shift / width / direction / fill controls
//     i_load_data value loaded when i_ctrl.load is set
//     o_data      current register contents
module shift_core
  import shift_seq_pkg::*;
#(
  parameter int NOBIT = 8
) (
  input  logic             i_clk,
  input  logic             i_clr_,
  input  core_ctrl_t       i_ctrl,
  input  logic [NOBIT-1:0] i_load_data,
  output logic [NOBIT-1:0] o_data
);

  logic [NOBIT-1:0] reg_q, reg_d;
  logic [NOBIT-1:0] shl1, shl2, shr1, shr2;

  // All four shift candidates are formed in parallel; the controls just pick one.
  always_comb begin
    shl1 = {reg_q[NOBIT-2:0], i_ctrl.fill};
    shl2 = {reg_q[NOBIT-3:0], i_ctrl.fill, i_ctrl.fill};
    shr1 = {i_ctrl.fill, reg_q[NOBIT-1:1]};
    shr2 = {i_ctrl.fill, i_ctrl.fill, reg_q[NOBIT-1:2]};
  end

  always_comb begin
    reg_d = reg_q;
    if (i_ctrl.load) begin
      reg_d = i_load_data;
    end else if (i_ctrl.shift_en) begin
      if (i_ctrl.dir == DIR_LEFT) reg_d = i_ctrl.shift_two ? shl2 : shl1;
      else                        reg_d = i_ctrl.shift_two ? shr2 : shr1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_clr_) reg_q <= '0;
    else         reg_q <= reg_d;
  end

  assign o_data = reg_q;

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Accepts one shift command over a valid/ready port, loads the shift
//   register, shifts it 2 positions per clock (1 on the final step when the
//   amount is odd) and presents the result on a valid/ready port.
//   Ports:
//     i_clk, i_clr_           clock / synchronous active-low reset
//     i_cmdValid, o_cmdReady  command handshake
//     i_cmdData               value to load
//     i_cmdAmt                shift amount (clamped to NOBIT)
//     i_cmdDir                0 = left, 1 = right
//     i_cmdFill               bit shifted into vacated positions
//     o_resValid, i_resReady  result handshake
//     o_resData               shifted result (held stable in DONE)
//     o_busy                  high in LOAD and SHIFT
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int NOBIT = 8,
  parameter int AW    = $clog2(NOBIT) + 1
) (
  input  logic             i_clk,
  input  logic             i_clr_,
  input  logic             i_cmdValid,
  output logic             o_cmdReady,
  input  logic [NOBIT-1:0] i_cmdData,
  input  logic [AW-1:0]    i_cmdAmt,
  input  logic             i_cmdDir,
  input  logic             i_cmdFill,
  output logic             o_resValid,
  input  logic             i_resReady,
  output logic [NOBIT-1:0] o_resData,
  output logic             o_busy
);

  localparam logic [AW-1:0] AMT_MAX = AW'(NOBIT);
  localparam logic [AW-1:0] TWO     = AW'(2);

  state_e           state_q, state_d;
  logic [NOBIT-1:0] dat_q, dat_d;
  logic [AW-1:0]    amt_q, amt_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;

  logic             cmd_fire;
  logic [AW-1:0]    amt_clamp;
  logic [AW-1:0]    rem_after;
  core_ctrl_t       core_ctrl;
  logic [NOBIT-1:0] core_data;

  // Any amount beyond NOBIT shifts every original bit out, so NOBIT is enough.
  assign amt_clamp = (i_cmdAmt > AMT_MAX) ? AMT_MAX : i_cmdAmt;
  assign cmd_fire  = (state_q == IDLE) && i_cmdValid;
  // Remaining count after this SHIFT edge; rem_q is never 0 while in SHIFT.
  assign rem_after = (rem_q >= TWO) ? (rem_q - TWO) : (rem_q - AW'(1));

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge i_clk) begin
    if (!i_clr_) begin
      state_q <= IDLE;
      dat_q   <= '0;
      amt_q   <= '0;
      rem_q   <= '0;
      dir_q   <= DIR_LEFT;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      amt_q   <= amt_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    amt_d   = amt_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          dat_d   = i_cmdData;
          amt_d   = amt_clamp;
          dir_d   = i_cmdDir;
          fill_d  = i_cmdFill;
          state_d = LOAD;
        end
      end
      LOAD: begin
        rem_d   = amt_q;
        state_d = (amt_q == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        rem_d = rem_after;
        if (rem_after == '0) state_d = DONE;
      end
      DONE: begin
        if (i_resReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  // Handshake flags decode from state_q only, so no input-to-output paths.
  always_comb begin
    o_cmdReady          = (state_q == IDLE);
    o_resValid          = (state_q == DONE);
    o_busy              = (state_q == LOAD) || (state_q == SHIFT);
    core_ctrl.load      = (state_q == LOAD);
    core_ctrl.shift_en  = (state_q == SHIFT);
    core_ctrl.shift_two = (rem_q >= TWO);
    core_ctrl.dir       = dir_q;
    core_ctrl.fill      = fill_q;
  end

  shift_core #(.NOBIT(NOBIT)) u_core (
    .i_clk       (i_clk),
    .i_clr_      (i_clr_),
    .i_ctrl      (core_ctrl),
    .i_load_data (dat_q),
    .o_data      (core_data)
  );

  assign o_resData = core_data;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
  localparam int NOBIT = 8;
  localparam int AW    = $clog2(NOBIT) + 1;

  logic             i_clk = 1'b0;
  logic             i_clr_ = 1'b0;
  logic             i_cmdValid = 1'b0;
  logic             o_cmdReady;
  logic [NOBIT-1:0] i_cmdData = '0;
  logic [AW-1:0]    i_cmdAmt = '0;
  logic             i_cmdDir = 1'b0;
  logic             i_cmdFill = 1'b0;
  logic             o_resValid;
  logic             i_resReady = 1'b0;
  logic [NOBIT-1:0] o_resData;
  logic             o_busy;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  shift_sequencer #(.NOBIT(NOBIT), .AW(AW)) dut (
    .i_clk      (i_clk),
    .i_clr_     (i_clr_),
    .i_cmdValid (i_cmdValid),
    .o_cmdReady (o_cmdReady),
    .i_cmdData  (i_cmdData),
    .i_cmdAmt   (i_cmdAmt),
    .i_cmdDir   (i_cmdDir),
    .i_cmdFill  (i_cmdFill),
    .o_resValid (o_resValid),
    .i_resReady (i_resReady),
    .o_resData  (o_resData),
    .o_busy     (o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a k-position shift moves data by k and fills k vacated bits.
  function automatic logic [NOBIT-1:0] model(input logic [NOBIT-1:0] d, input int a,
                                             input logic dir, input logic fill);
    int k;
    logic [31:0] ones;
    logic [31:0] r;
    k = (a > NOBIT) ? NOBIT : a;
    ones = (32'h1 << k) - 32'h1;
    if (!dir) r = (32'(d) << k) | (fill ? ones : 32'h0);
    else      r = (32'(d) >> k) | (fill ? (ones << (NOBIT - k)) : 32'h0);
    return r[NOBIT-1:0];
  endfunction

  function automatic int model_lat(input int a);
    int k;
    k = (a > NOBIT) ? NOBIT : a;
    return 1 + (k + 1) / 2;
  endfunction

  // Issue one command, measure latency and busy time, hold the result for
  // `hold` cycles (optionally poking a second command), then drain it.
  task automatic do_cmd(input string tag, input logic [NOBIT-1:0] d, input int a,
                        input logic dir, input logic fill, input int hold, input bit poke);
    logic [NOBIT-1:0] exp;
    int edges;
    int busy_cnt;
    exp = model(d, a, dir, fill);
    @(negedge i_clk);
    chk({tag, ".ready"}, 32'(o_cmdReady), 32'd1);
    i_cmdValid = 1'b1; i_cmdData = d; i_cmdAmt = AW'(a);
    i_cmdDir = dir; i_cmdFill = fill;
    @(negedge i_clk);
    i_cmdValid = 1'b0;
    edges = 0; busy_cnt = 0;
    while (!o_resValid && edges < 40) begin
      if (o_busy) busy_cnt++;
      @(negedge i_clk);
      edges++;
    end
    chk({tag, ".lat"}, 32'(edges), 32'(model_lat(a)));
    chk({tag, ".busy"}, 32'(busy_cnt), 32'(model_lat(a)));
    chk({tag, ".data"}, 32'(o_resData), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        i_cmdValid = i[0]; i_cmdData = ~d; i_cmdAmt = AW'(1);
      end
      @(negedge i_clk);
      chk({tag, ".hold_data"}, 32'(o_resData), 32'(exp));
      chk({tag, ".hold_vld"}, 32'(o_resValid), 32'd1);
      chk({tag, ".hold_rdy"}, 32'(o_cmdReady), 32'd0);
    end
    i_cmdValid = 1'b0;
    i_resReady = 1'b1;
    @(negedge i_clk);
    i_resReady = 1'b0;
    chk({tag, ".drain_vld"}, 32'(o_resValid), 32'd0);
    chk({tag, ".drain_rdy"}, 32'(o_cmdReady), 32'd1);
    chk({tag, ".drain_busy"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    // Reset held 2 cycles with a command request pending.
    i_clr_ = 1'b0; i_cmdValid = 1'b1; i_cmdData = 8'hC3; i_cmdAmt = AW'(2);
    repeat (2) @(negedge i_clk);
    chk("rst.ready", 32'(o_cmdReady), 32'd1);
    chk("rst.valid", 32'(o_resValid), 32'd0);
    chk("rst.data", 32'(o_resData), 32'd0);
    chk("rst.busy", 32'(o_busy), 32'd0);
    i_clr_ = 1'b1; i_cmdValid = 1'b0;
    @(negedge i_clk);
    chk("rst.no_accept", 32'(o_busy), 32'd0);

    do_cmd("odd_left", 8'hB5, 3, 1'b0, 1'b0, 0, 1'b0);
    chk("odd_left.val", 32'(model(8'hB5, 3, 1'b0, 1'b0)), 32'h0A8);
    do_cmd("even_right", 8'hB5, 4, 1'b1, 1'b1, 0, 1'b0);
    do_cmd("zero_amt", 8'h3C, 0, 1'b0, 1'b1, 0, 1'b0);
    do_cmd("clamp", 8'h5A, 12, 1'b0, 1'b1, 0, 1'b0);
    do_cmd("clamp_r", 8'h5A, 15, 1'b1, 1'b0, 0, 1'b0);
    do_cmd("backpressure", 8'hB5, 3, 1'b0, 1'b0, 6, 1'b1);

    // Reset during the second SHIFT cycle of an amount-8 command.
    @(negedge i_clk);
    i_cmdValid = 1'b1; i_cmdData = 8'hA5; i_cmdAmt = AW'(8); i_cmdDir = 1'b0; i_cmdFill = 1'b1;
    @(negedge i_clk);              // LOAD
    i_cmdValid = 1'b0;
    @(negedge i_clk);              // first SHIFT cycle
    @(negedge i_clk);              // second SHIFT cycle
    chk("midrst.pre_busy", 32'(o_busy), 32'd1);
    i_clr_ = 1'b0;
    @(negedge i_clk);
    i_clr_ = 1'b1;
    chk("midrst.ready", 32'(o_cmdReady), 32'd1);
    chk("midrst.valid", 32'(o_resValid), 32'd0);
    chk("midrst.data", 32'(o_resData), 32'd0);
    chk("midrst.busy", 32'(o_busy), 32'd0);
    do_cmd("after_rst", 8'h96, 5, 1'b1, 1'b0, 1, 1'b0);

    // Randomized commands with random backpressure.
    for (int n = 0; n < 30; n++) begin
      do_cmd("rand", 8'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
             1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
